ps2_dev_port: RTL and testbench
===============================

Name: ps2_dev_port

Overview:
Parametrised PS/2 device-side emulator port, one instance per channel (keyboard, mouse), placed between the HPS command decoder and the core's PS/2 host logic. Buffers bytes from the HPS in a configurable-depth FIFO and serialises them as PS/2 device-to-host frames. Unlike the fixed transmit-only emulation, it honours host clock inhibit, aborting and retrying the frame. It also receives host-to-device command frames (for example LED or reset commands), checks them and acknowledges them.

Parameters:
PS2DIV, 1000, clk_sys cycles per PS/2 half-period (min 4)
FIFO_BITS, 3, log2 of TX FIFO depth (depth = 1<<FIFO_BITS)
RX_EN, 1, 1 = host-to-device receive enabled; 0 = request-to-send ignored, RX outputs held 0

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr  in  1  FIFO push strobe, one byte per cycle
din  in  8  byte to push
full  out  1  FIFO full
empty  out  1  FIFO empty
overflow  out  1  one-cycle pulse: wr while full, byte dropped
busy  out  1  TX, RX or ACK frame in progress
ps2_clk_in  in  1  PS/2 clock line as seen by the host (wired-AND)
ps2_data_in  in  1  PS/2 data line as seen by the host
ps2_clk_out  out  1  device clock drive; 1 = released
ps2_data_out  out  1  device data drive; 1 = released
rx_byte  out  8  last received host byte
rx_strobe  out  1  one-cycle pulse: valid host byte in rx_byte
rx_error  out  1  one-cycle pulse: host frame had a parity or stop error

Behaviour:
- Reset (async, reset_n=0):
  - FIFO pointers 0, so empty=1 and full=0.
  - State IDLE; divider 0; phase high.
  - ps2_clk_out=1, ps2_data_out=1.
  - rx_byte=0; rx_strobe, rx_error, overflow, busy=0.
  - Synchronisers preset to 1.
  - Reset mid-frame abandons the frame and the unsent byte stays in the FIFO only if reset is not asserted; reset always empties the FIFO.
- Divider:
  - Free-running counter 0..PS2DIV-1; the phase toggles at wrap.
  - Phase low->high = rise tick; high->low = fall tick.
  - ps2_clk_out = phase in TX/RX/ACK, else 1.
- Inputs: ps2_clk_in and ps2_data_in pass through 2-flop synchronisers (clk_s, data_s) before any use.
- FIFO:
  - wr && !full pushes.
  - wr && full pulses overflow; pointers unchanged.
  - A push and a pop in the same cycle both occur; the count is unchanged.
  - A pop happens only on TX completion; the head is peeked during TX.
- IDLE, checked at rise tick, in priority order:
  - RTS: if RX_EN, rts_seen=1, clk_s=1 and data_s=0 -> RX, rx_cnt=0. rts_seen is set whenever clk_s=0 and data_s=0 in IDLE, and cleared on RX entry.
  - Start TX: else if !empty and clk_s=1 -> TX, tx_cnt=1, ps2_data_out=0 (start bit), shift register = head byte, parity seed 1.
- TX:
  - Each rise tick advances tx_cnt.
  - tx_cnt 1-8 drive data bits LSB first; tx_cnt 9 drives odd parity (~^byte); tx_cnt 10 drives stop=1.
  - At tx_cnt 11: pop FIFO, go IDLE, data released.
  - Inhibit: at any fall tick with tx_cnt<=9 and clk_s=0 (host holding the released clock), go IDLE immediately. Both lines are released, no pop, and the byte is retried later.
- RX:
  - At each rise tick, sample data_s: samples 1-8 are bits LSB first, sample 9 is parity, sample 10 is stop.
  - At sample 10: ps2_data_out=0 -> ACK.
- ACK:
  - At next rise tick release data and go IDLE.
  - If parity is odd over the 9 bits and stop=1: rx_byte updates and rx_strobe=1 for one cycle. Otherwise rx_error=1 for one cycle and rx_byte is unchanged.
- busy=1 in TX/RX/ACK.
- Frame length: TX is 11 clock pulses.
- RTS arriving during TX is handled only after the TX completes or is aborted.

Test Plan:
- Push 0x1C, no host activity -> frame start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1. ps2_clk_out shows 11 low pulses each PS2DIV cycles wide. Afterwards empty=1 and busy=0.
- Push 9 bytes 0x01..0x09 with FIFO_BITS=3 -> full=1 after 8 pushes, overflow pulse on the 9th. Output frames carry 0x01..0x08 in order.
- During TX of 0xF4, host pulls clock low at data bit 3 -> abort to IDLE, lines released. After the host releases, 0xF4 is retransmitted in full and the FIFO pops once.
- Host RTS, then sends 0xED with parity 1 and stop 1 -> ACK low for one period, rx_byte=0xED, one rx_strobe.
- Host sends 0xED with parity 0 -> ACK driven, rx_error pulse, rx_byte unchanged, no rx_strobe.
- Assert reset_n=0 mid-TX with 3 bytes queued -> both lines immediately 1, empty=1, busy=0. After release, no frame is sent.

Source files
------------

// File: rtl/ps2_dev_port.sv
// PS/2 device-side emulator port. Bytes queued from the HPS side are sent as
// device-to-host frames, with host clock inhibit aborting the frame so it can
// be retried. Host-to-device command frames are received, checked and acked.
//
// Handshake: wr is a one-cycle push strobe with no ready; full tells the
// writer to stop, and a wr while full is dropped and flagged on overflow.
module ps2_dev_port #(
  parameter int PS2DIV    = 1000,
  parameter int FIFO_BITS = 3,
  parameter int RX_EN     = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_error
);

  localparam int DW = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [DW-1:0] DIV_LAST = DW'(PS2DIV - 1);

  typedef enum logic [1:0] {IDLE, TX, RX, ACK} state_t;

  state_t state, state_d;

  logic [DW-1:0]      div;
  logic               phase;
  logic               rise_tick, fall_tick;
  logic               clk_meta, clk_s, data_meta, data_s;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_BITS:0] wr_ptr, rd_ptr;
  logic [7:0]         head;
  logic               push;
  logic               rts_seen;
  logic [3:0]         tx_cnt, rx_cnt;
  logic [7:0]         tx_sh;
  logic               tx_par;
  logic [8:0]         rx_sh;
  logic               rx_stop;
  logic               start_tx, start_rx, tx_step, tx_done, tx_abort, rx_step, ack_done;

  // Phase flips each time the divider wraps; the flip direction names the tick.
  assign rise_tick = (div == DIV_LAST) && !phase;
  assign fall_tick = (div == DIV_LAST) && phase;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]) &&
                 (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]);
  assign push  = wr && !full;
  assign head  = mem[rd_ptr[FIFO_BITS-1:0]];

  assign busy        = (state != IDLE);
  assign ps2_clk_out = busy ? phase : 1'b1;

  // Free-running half-period divider.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div   <= '0;
      phase <= 1'b1;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      phase <= ~phase;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Two-flop synchronisers for the wired-AND lines, idle-high after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_s     <= clk_meta;
      data_meta <= ps2_data_in;
      data_s    <= data_meta;
    end
  end

  // FIFO storage; only the pointers need reset.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[FIFO_BITS-1:0]] <= din;
  end

  // FIFO pointers and overflow flag; a pop only happens when a frame completes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr && full;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (tx_done) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state and per-tick control strobes for the datapath.
  always_comb begin
    state_d  = state;
    start_tx = 1'b0;
    start_rx = 1'b0;
    tx_step  = 1'b0;
    tx_done  = 1'b0;
    tx_abort = 1'b0;
    rx_step  = 1'b0;
    ack_done = 1'b0;
    case (state)
      IDLE: begin
        if (rise_tick) begin
          if ((RX_EN != 0) && rts_seen && clk_s && !data_s) begin
            state_d  = RX;
            start_rx = 1'b1;
          end else if (!empty && clk_s) begin
            state_d  = TX;
            start_tx = 1'b1;
          end
        end
      end
      TX: begin
        // Host holding our released clock low means inhibit: drop the frame.
        if (fall_tick && (tx_cnt <= 4'd9) && !clk_s) begin
          state_d  = IDLE;
          tx_abort = 1'b1;
        end else if (rise_tick) begin
          if (tx_cnt == 4'd11) begin
            state_d = IDLE;
            tx_done = 1'b1;
          end else begin
            tx_step = 1'b1;
          end
        end
      end
      RX: begin
        if (rise_tick) begin
          rx_step = 1'b1;
          if (rx_cnt == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (rise_tick) begin
          state_d  = IDLE;
          ack_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: shift registers, bit counters, data drive and RX results.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rts_seen     <= 1'b0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      tx_sh        <= '0;
      tx_par       <= 1'b1;
      rx_sh        <= '0;
      rx_stop      <= 1'b0;
      ps2_data_out <= 1'b1;
      rx_byte      <= '0;
      rx_strobe    <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      rx_error  <= 1'b0;

      if (start_rx)
        rts_seen <= 1'b0;
      else if ((RX_EN != 0) && (state == IDLE) && !clk_s && !data_s)
        rts_seen <= 1'b1;

      if (start_tx) begin
        tx_cnt       <= 4'd1;
        ps2_data_out <= 1'b0;
        tx_sh        <= head;
        tx_par       <= 1'b1;
      end else if (tx_step) begin
        tx_cnt <= tx_cnt + 4'd1;
        if (tx_cnt <= 4'd8) begin
          ps2_data_out <= tx_sh[0];
          tx_par       <= tx_par ^ tx_sh[0];
          tx_sh        <= {1'b0, tx_sh[7:1]};
        end else if (tx_cnt == 4'd9) begin
          ps2_data_out <= tx_par;
        end else begin
          ps2_data_out <= 1'b1;
        end
      end else if (tx_done || tx_abort) begin
        tx_cnt       <= '0;
        ps2_data_out <= 1'b1;
      end

      if (start_rx) begin
        rx_cnt <= '0;
      end else if (rx_step) begin
        rx_cnt <= rx_cnt + 4'd1;
        if (rx_cnt <= 4'd8) begin
          rx_sh <= {data_s, rx_sh[8:1]};
        end else begin
          rx_stop      <= data_s;
          ps2_data_out <= 1'b0;
        end
      end

      if (ack_done) begin
        ps2_data_out <= 1'b1;
        if ((^rx_sh) && rx_stop) begin
          rx_byte   <= rx_sh[7:0];
          rx_strobe <= 1'b1;
        end else begin
          rx_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_dev_port.sv
// Directed bench for ps2_dev_port: a host model on the wired-AND lines decodes
// device frames, inhibits the clock, and sends command frames to the port.
module tb_ps2_dev_port;

  localparam int DIV = 8;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, overflow, busy;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_out, ps2_data_out;
  logic [7:0] rx_byte;
  logic       rx_strobe, rx_error;
  logic       host_clk = 1'b1;
  logic       host_data = 1'b1;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_rxerr = 0;
  int n_falls = 0;

  ps2_dev_port #(.PS2DIV(DIV), .FIFO_BITS(3), .RX_EN(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr(wr), .din(din),
    .full(full), .empty(empty), .overflow(overflow), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .rx_error(rx_error)
  );

  // Clock and wired-AND bus.
  always #5 clk_sys = ~clk_sys;
  assign ps2_clk_in  = ps2_clk_out & host_clk;
  assign ps2_data_in = ps2_data_out & host_data;

  // Event counters for pulse outputs and device clock falls.
  always @(posedge clk_sys) begin
    if (rx_strobe) n_strobe <= n_strobe + 1;
    if (rx_error)  n_rxerr  <= n_rxerr + 1;
  end
  always @(negedge ps2_clk_out) n_falls <= n_falls + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    @(negedge clk_sys);
    wr  = 1'b0;
  endtask

  // Wait (bounded) until the device clock drive reaches lvl.
  task automatic wait_clk(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (ps2_clk_out === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  // Host side of a device-to-host frame: sample data on each clock low.
  task automatic recv_frame(output logic [10:0] bits, output int bad_width, output bit ok);
    bit g;
    int width;
    bits = '0;
    bad_width = 0;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_clk(1'b0, 8 * DIV, g);
      if (!g) begin
        ok = 1'b0;
        break;
      end
      bits[i] = ps2_data_out;
      width = 0;
      for (int k = 0; k < 4 * DIV; k++) begin
        @(negedge clk_sys);
        width++;
        if (ps2_clk_out === 1'b1) break;
      end
      if (width != DIV) bad_width++;
    end
  endtask

  task automatic expect_frame(input string tag);
    logic [7:0]  e;
    logic [10:0] bits;
    int bw;
    bit ok;
    e = exp_q.pop_front();
    recv_frame(bits, bw, ok);
    check({tag, " done"}, 32'(ok), 32'd1);
    check({tag, " frame"}, 32'(bits), 32'({1'b1, ~^e, e, 1'b0}));
    check({tag, " width"}, 32'(bw), 32'd0);
  endtask

  // Host-to-device frame: RTS, then one bit per device clock low, then ACK.
  task automatic host_send(input logic [7:0] b, input logic par, input logic stop,
                           output int ack_len, output bit ok);
    logic [9:0] bits;
    bit g;
    ok = 1'b1;
    bits = {stop, par, b};
    host_clk = 1'b0;
    repeat (3 * DIV) @(negedge clk_sys);
    host_data = 1'b0;
    repeat (4) @(negedge clk_sys);
    host_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk(1'b0, 8 * DIV, g);
      if (!g) ok = 1'b0;
      host_data = bits[i];
      wait_clk(1'b1, 4 * DIV, g);
      if (!g) ok = 1'b0;
    end
    host_data = 1'b1;
    ack_len = 0;
    for (int i = 0; i < 6 * DIV; i++) begin
      if (ps2_data_out === 1'b0) ack_len++;
      else if (ack_len > 0) break;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    logic [10:0] bits;
    int bw, ack_len, s0, e0, f0;
    bit ok;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst clk_out", 32'(ps2_clk_out), 32'd1);
    check("rst data_out", 32'(ps2_data_out), 32'd1);
    check("rst rx_byte", 32'(rx_byte), 32'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Single byte 0x1C: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1
    push(8'h1C);
    recv_frame(bits, bw, ok);
    check("1c done", 32'(ok), 32'd1);
    check("1c frame", 32'(bits), 32'h438);
    check("1c width", 32'(bw), 32'd0);
    repeat (3) @(negedge clk_sys);
    check("1c empty", 32'(empty), 32'd1);
    check("1c busy", 32'(busy), 32'd0);
    check("1c data idle", 32'(ps2_data_out), 32'd1);

    // FIFO fill to full and overflow, then drain in order
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    check("fifo full", 32'(full), 32'd1);
    check("fifo ovf before", 32'(overflow), 32'd0);
    push(8'h09);
    check("fifo ovf pulse", 32'(overflow), 32'd1);
    @(negedge clk_sys);
    check("fifo ovf end", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) expect_frame($sformatf("fifo byte %0d", i));
    repeat (3) @(negedge clk_sys);
    check("fifo drained", 32'(empty), 32'd1);

    // Host inhibit during data bits aborts, then the byte is resent
    push(8'hF4);
    for (int k = 0; k < 5; k++) begin
      wait_clk(1'b0, 8 * DIV, ok);
      wait_clk(1'b1, 4 * DIV, ok);
    end
    host_clk = 1'b0;
    repeat (3 * DIV) @(negedge clk_sys);
    check("inh busy", 32'(busy), 32'd0);
    check("inh clk rel", 32'(ps2_clk_out), 32'd1);
    check("inh data rel", 32'(ps2_data_out), 32'd1);
    check("inh kept", 32'(empty), 32'd0);
    host_clk = 1'b1;
    exp_q.push_back(8'hF4);
    expect_frame("retry f4");
    repeat (3) @(negedge clk_sys);
    check("retry popped", 32'(empty), 32'd1);

    // Host sends 0xED with bad parity: ACK, error pulse, rx_byte kept
    s0 = n_strobe;
    e0 = n_rxerr;
    host_send(8'hED, 1'b0, 1'b1, ack_len, ok);
    repeat (3) @(negedge clk_sys);
    check("bad rx done", 32'(ok), 32'd1);
    check("bad ack len", 32'(ack_len), 32'(2 * DIV));
    check("bad rx_error", 32'(n_rxerr - e0), 32'd1);
    check("bad no strobe", 32'(n_strobe - s0), 32'd0);
    check("bad rx_byte", 32'(rx_byte), 32'h00);

    // Host sends 0xED with parity 1: ACK, one strobe
    repeat (2 * DIV) @(negedge clk_sys);
    s0 = n_strobe;
    e0 = n_rxerr;
    host_send(8'hED, 1'b1, 1'b1, ack_len, ok);
    repeat (3) @(negedge clk_sys);
    check("good rx done", 32'(ok), 32'd1);
    check("good ack len", 32'(ack_len), 32'(2 * DIV));
    check("good strobe", 32'(n_strobe - s0), 32'd1);
    check("good no error", 32'(n_rxerr - e0), 32'd0);
    check("good rx_byte", 32'(rx_byte), 32'hED);
    check("good busy", 32'(busy), 32'd0);

    // Reset mid-frame with bytes queued: lines released, FIFO emptied
    repeat (2 * DIV) @(negedge clk_sys);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_clk(1'b0, 8 * DIV, ok);
    check("rst tx started", 32'(ok), 32'd1);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("mid rst clk", 32'(ps2_clk_out), 32'd1);
    check("mid rst data", 32'(ps2_data_out), 32'd1);
    check("mid rst empty", 32'(empty), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    f0 = n_falls;
    repeat (40 * DIV) @(negedge clk_sys);
    check("post rst no frame", 32'(n_falls - f0), 32'd0);
    check("post rst empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
